alu_issue_stage: RTL

//  Operand-fetch / issue stage directly upstream of the 8-bit ALU; consumes its combinational result.

---
 rtl/alu_issue_stage.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// Operand-fetch / issue stage in front of the 8-bit ALU: reads operands from a small
// register file, drives the ALU from registers, writes the result back and returns it with flags.
module alu_issue_stage #(
    parameter int BITS   = 8,
    parameter int ALUOP  = 4,
    parameter int REGS   = 4,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ALUOP-1:0]  cmd_op,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic [REG_AW-1:0] cmd_ra,
    input  logic [REG_AW-1:0] cmd_rb,
    input  logic [BITS-1:0]   cmd_imm,
    input  logic              cmd_use_imm,
    output logic [ALUOP-1:0]  alu_function,
    output logic [BITS-1:0]   alu_vector_a,
    output logic [BITS-1:0]   alu_vector_b,
    input  logic [BITS-1:0]   alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [BITS-1:0]   rsp_data,
    output logic              rsp_zero,
    output logic              rsp_carry,
    output logic              rsp_err
);

    // state | meaning
    // IDLE  | waiting for a command; operands are read and registered on accept
    // EXEC  | ALU output settles; result captured, flags computed, writeback
    // RESP  | response held until the consumer takes it
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [ALUOP-1:0] OP_ADD = ALUOP'(1);
    localparam logic [ALUOP-1:0] OP_SUB = ALUOP'(2);
    localparam logic [ALUOP-1:0] OP_MAX = ALUOP'(9);

    state_t              state_q, state_d;
    logic [BITS-1:0]     rf_q [REGS];
    logic [BITS-1:0]     rf_d [REGS];
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic                err_q, err_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic [ALUOP-1:0]    alu_function_q, alu_function_d;
    logic [BITS-1:0]     alu_vector_a_q, alu_vector_a_d;
    logic [BITS-1:0]     alu_vector_b_q, alu_vector_b_d;
    logic [BITS-1:0]     rsp_data_q, rsp_data_d;
    logic                rsp_zero_q, rsp_zero_d;
    logic                rsp_carry_q, rsp_carry_d;
    logic                rsp_err_q, rsp_err_d;
    logic                add_carry;
    logic                sub_borrow;

    // Carry/borrow taken from the top bit of a one-bit-wider add/sub of the registered operands.
    assign add_carry  = |(({1'b0, alu_vector_a_q} + {1'b0, alu_vector_b_q}) >> BITS);
    assign sub_borrow = |(({1'b0, alu_vector_a_q} - {1'b0, alu_vector_b_q}) >> BITS);

    always_comb begin
        state_d        = state_q;
        rf_d           = rf_q;
        rd_d           = rd_q;
        err_d          = err_q;
        alu_function_d = alu_function_q;
        alu_vector_a_d = alu_vector_a_q;
        alu_vector_b_d = alu_vector_b_q;
        rsp_data_d     = rsp_data_q;
        rsp_zero_d     = rsp_zero_q;
        rsp_carry_d    = rsp_carry_q;
        rsp_err_d      = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    alu_function_d = cmd_op;
                    alu_vector_a_d = rf_q[cmd_ra];
                    alu_vector_b_d = cmd_use_imm ? cmd_imm : rf_q[cmd_rb];
                    rd_d           = cmd_rd;
                    err_d          = (cmd_op == '0) || (cmd_op > OP_MAX);
                    state_d        = EXEC;
                end
            end
            EXEC: begin
                rsp_err_d = err_q;
                if (err_q) begin
                    rsp_data_d  = '0;
                    rsp_zero_d  = 1'b1;
                    rsp_carry_d = 1'b0;
                end else begin
                    rsp_data_d  = alu_result;
                    rsp_zero_d  = (alu_result == '0);
                    rsp_carry_d = (alu_function_q == OP_ADD) ? add_carry :
                                  (alu_function_q == OP_SUB) ? sub_borrow : 1'b0;
                    rf_d[rd_q]  = alu_result;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            for (int i = 0; i < REGS; i++) begin
                rf_q[i] <= '0;
            end
            rd_q           <= '0;
            err_q          <= 1'b0;
            cmd_ready_q    <= 1'b0;
            alu_function_q <= '0;
            alu_vector_a_q <= '0;
            alu_vector_b_q <= '0;
            rsp_data_q     <= '0;
            rsp_zero_q     <= 1'b0;
            rsp_carry_q    <= 1'b0;
            rsp_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            rf_q           <= rf_d;
            rd_q           <= rd_d;
            err_q          <= err_d;
            cmd_ready_q    <= cmd_ready_d;
            alu_function_q <= alu_function_d;
            alu_vector_a_q <= alu_vector_a_d;
            alu_vector_b_q <= alu_vector_b_d;
            rsp_data_q     <= rsp_data_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_carry_q    <= rsp_carry_d;
            rsp_err_q      <= rsp_err_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign alu_function = alu_function_q;
    assign alu_vector_a = alu_vector_a_q;
    assign alu_vector_b = alu_vector_b_q;
    assign rsp_valid    = (state_q == RESP);
    assign rsp_data     = rsp_data_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_err      = rsp_err_q;

endmodule
